// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: binary HH:MM:SS counter advanced by a 1 Hz tick, with a validated time load.
// Define RTC_TIMEKEEPER_ALARM_EN to compile in the sticky alarm compare.
module rtc_timekeeper #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [5:0] set_sec,
  input  logic [5:0] set_min,
  input  logic [4:0] set_hr,
  output logic       set_err,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic       day_pulse
`ifdef RTC_TIMEKEEPER_ALARM_EN
  ,
  input  logic [5:0] alarm_sec,
  input  logic [5:0] alarm_min,
  input  logic [4:0] alarm_hr,
  input  logic       alarm_arm,
  input  logic       alarm_clr,
  output logic       alarm_flag
`endif
);

  localparam logic [4:0] HR_LAST = 5'(HOUR_MAX);

  typedef enum logic [1:0] {IDLE, ADVANCE, LOAD} state_t;

  state_t     state, state_nxt;
  logic       pending, pending_nxt;
  logic       accept;
  logic [5:0] ld_sec_p1, ld_min_p1;
  logic [4:0] ld_hr_p1;
  logic       ld_ok_p1;

  function automatic logic load_ok(input logic [5:0] s, input logic [5:0] m,
                                   input logic [4:0] h);
    return (s <= 6'd59) && (m <= 6'd59) && (h <= HR_LAST);
  endfunction

  // A load in IDLE wins over a tick; a pending tick survives the load.
  always_comb begin
    state_nxt   = IDLE;
    pending_nxt = pending;
    set_ready   = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        set_ready = 1'b1;
        if (set_valid) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end else if (tick || pending) begin
          state_nxt   = ADVANCE;
          pending_nxt = 1'b0;
        end
      end
      default: begin
        if (tick) pending_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      set_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      set_err <= accept && !load_ok(set_sec, set_min, set_hr);
    end
  end

  // p1: load operands captured only in the accept cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      ld_sec_p1 <= set_sec;
      ld_min_p1 <= set_min;
      ld_hr_p1  <= set_hr;
      ld_ok_p1  <= load_ok(set_sec, set_min, set_hr);
    end
  end

  // p2: time registers, updated at the end of an ADVANCE or LOAD cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sec       <= '0;
      min       <= '0;
      hr        <= '0;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= 1'b0;
      if (state == ADVANCE) begin
        if (sec == 6'd59) begin
          sec <= '0;
          if (min == 6'd59) begin
            min <= '0;
            if (hr == HR_LAST) begin
              hr        <= '0;
              day_pulse <= 1'b1;
            end else begin
              hr <= hr + 5'd1;
            end
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end else if (state == LOAD && ld_ok_p1) begin
        sec <= ld_sec_p1;
        min <= ld_min_p1;
        hr  <= ld_hr_p1;
      end
    end
  end

`ifdef RTC_TIMEKEEPER_ALARM_EN
  logic vld_p2;

  // p3: compare the freshly updated time; a new match beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      alarm_flag <= 1'b0;
    end else begin
      vld_p2 <= (state != IDLE);
      if (vld_p2 && alarm_arm && sec == alarm_sec && min == alarm_min && hr == alarm_hr)
        alarm_flag <= 1'b1;
      else if (alarm_clr)
        alarm_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: 24 h and 12 h instances share stimulus; a seconds-of-day
// reference model feeds per-instance scoreboards checked by a negedge monitor.
module tb_rtc_timekeeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       set_valid = 1'b0;
  logic [5:0] set_sec = '0;
  logic [5:0] set_min = '0;
  logic [4:0] set_hr = '0;
  logic       rdy_a, err_a, day_a, rdy_b, err_b, day_b;
  logic [5:0] sec_a, min_a, sec_b, min_b;
  logic [4:0] hr_a, hr_b;
`ifdef RTC_TIMEKEEPER_ALARM_EN
  logic [5:0] alarm_sec = '0;
  logic [5:0] alarm_min = '0;
  logic [4:0] alarm_hr = '0;
  logic       alarm_arm = 1'b0;
  logic       alarm_clr = 1'b0;
  logic       af_a, af_b;
`endif

  always #5 clk = ~clk;

  rtc_timekeeper #(.HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid), .set_ready(rdy_a),
    .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr), .set_err(err_a),
    .sec(sec_a), .min(min_a), .hr(hr_a), .day_pulse(day_a)
`ifdef RTC_TIMEKEEPER_ALARM_EN
    , .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
    .alarm_arm(alarm_arm), .alarm_clr(alarm_clr), .alarm_flag(af_a)
`endif
  );

  rtc_timekeeper #(.HOUR_MAX(11)) dut12 (
    .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid), .set_ready(rdy_b),
    .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr), .set_err(err_b),
    .sec(sec_b), .min(min_b), .hr(hr_b), .day_pulse(day_b)
`ifdef RTC_TIMEKEEPER_ALARM_EN
    , .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
    .alarm_arm(alarm_arm), .alarm_clr(alarm_clr), .alarm_flag(af_b)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    int s, m, h;
    bit day, err, rdy, af;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: time kept as seconds of day, one operation in flight at a time.
  int hmax[2] = '{23, 11};
  int mt[2], mbusy[2], mld[2];
  bit mpend[2], mldok[2], merr[2], mday[2], mupd[2], maf[2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit   ok;
      int   period;
      period = (hmax[k] + 1) * 3600;
      if (rst) begin
        mt[k] = 0; mbusy[k] = 0; mpend[k] = 0; merr[k] = 0;
        mday[k] = 0; mupd[k] = 0; maf[k] = 0;
      end else begin
`ifdef RTC_TIMEKEEPER_ALARM_EN
        if (mupd[k] && alarm_arm && mt[k] % 60 == int'(alarm_sec) &&
            (mt[k] / 60) % 60 == int'(alarm_min) && mt[k] / 3600 == int'(alarm_hr))
          maf[k] = 1;
        else if (alarm_clr)
          maf[k] = 0;
`endif
        mupd[k] = (mbusy[k] != 0);
        merr[k] = 0;
        mday[k] = 0;
        if (mbusy[k] == 0) begin
          if (set_valid) begin
            ok = int'(set_sec) <= 59 && int'(set_min) <= 59 && int'(set_hr) <= hmax[k];
            mldok[k] = ok;
            mld[k] = int'(set_hr) * 3600 + int'(set_min) * 60 + int'(set_sec);
            merr[k] = !ok;
            mbusy[k] = 2;
          end else if (tick || mpend[k]) begin
            mbusy[k] = 1;
            mpend[k] = 0;
          end
        end else begin
          if (mbusy[k] == 1) begin
            mt[k] = (mt[k] + 1) % period;
            mday[k] = (mt[k] == 0);
          end else if (mldok[k]) begin
            mt[k] = mld[k];
          end
          mbusy[k] = 0;
          if (tick) mpend[k] = 1;
        end
      end
      e.s = mt[k] % 60;
      e.m = (mt[k] / 60) % 60;
      e.h = mt[k] / 3600;
      e.day = mday[k];
      e.err = merr[k];
      e.rdy = (mbusy[k] == 0);
      e.af = maf[k];
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(input string tag, input exp_t e, input int s, input int m, input int h,
                     input bit day, input bit err, input bit rdy, input bit af);
    chk({tag, "_sec"}, s, e.s);
    chk({tag, "_min"}, m, e.m);
    chk({tag, "_hr"}, h, e.h);
    chk({tag, "_day_pulse"}, int'(day), int'(e.day));
    chk({tag, "_set_err"}, int'(err), int'(e.err));
    chk({tag, "_set_ready"}, int'(rdy), int'(e.rdy));
`ifdef RTC_TIMEKEEPER_ALARM_EN
    chk({tag, "_alarm_flag"}, int'(af), int'(e.af));
`else
    if (af) chk({tag, "_alarm_flag"}, 1, 0);
`endif
  endtask

  initial forever begin
    @(negedge clk);
    if (q0.size() > 0 && q1.size() > 0) begin
      exp_t e0, e1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
`ifdef RTC_TIMEKEEPER_ALARM_EN
      cmp("sb24", e0, sec_a, min_a, hr_a, day_a, err_a, rdy_a, af_a);
      cmp("sb12", e1, sec_b, min_b, hr_b, day_b, err_b, rdy_b, af_b);
`else
      cmp("sb24", e0, sec_a, min_a, hr_a, day_a, err_a, rdy_a, 1'b0);
      cmp("sb12", e1, sec_b, min_b, hr_b, day_b, err_b, rdy_b, 1'b0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    set_valid = 1'b0;
`ifdef RTC_TIMEKEEPER_ALARM_EN
    alarm_clr = 1'b0;
`endif
    repeat (n) step();
  endtask

  // Issues a load in an IDLE cycle and returns two cycles later, when it is visible.
  task automatic load(input int h, input int m, input int s);
    set_hr = 5'(h);
    set_min = 6'(m);
    set_sec = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hr"}, hr_a, h);
    chk({tag, "_min"}, min_a, m);
    chk({tag, "_sec"}, sec_a, s);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    chk_time("reset", 0, 0, 0);
    chk("reset_day_pulse", day_a, 0);
    chk("reset_set_err", err_a, 0);
    chk("reset_set_ready", rdy_a, 1);

    // 00:00:58, two ticks far apart
    idle(3);
    load(0, 0, 58);
    chk_time("load58", 0, 0, 58);
    tick = 1'b1; step(); tick = 1'b0;
    chk("tick_n1_sec", sec_a, 58);
    step();
    chk("tick_n2_sec", sec_a, 59);
    chk("tick_n2_day", day_a, 0);
    idle(1000);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk_time("min_carry", 0, 1, 0);
    chk("min_carry_day", day_a, 0);

    // day wrap on both clock lengths
    idle(3);
    load(23, 59, 59);
    chk("load23_err12", err_b, 0);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk_time("wrap24", 0, 0, 0);
    chk("wrap24_day", day_a, 1);
    step();
    chk("wrap24_day_off", day_a, 0);
    idle(3);
    load(11, 59, 59);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("wrap12_hr", hr_b, 0);
    chk("wrap12_min", min_b, 0);
    chk("wrap12_sec", sec_b, 0);
    chk("wrap12_day", day_b, 1);
    chk("no_wrap24_hr", hr_a, 12);
    chk("no_wrap24_day", day_a, 0);

    // tick and load in the same cycle: load wins
    idle(3);
    set_hr = 5'd12; set_min = 6'd34; set_sec = 6'd56;
    tick = 1'b1; set_valid = 1'b1; step();
    tick = 1'b0; set_valid = 1'b0; step();
    chk_time("tick_vs_load", 12, 34, 56);
    idle(4);
    chk_time("tick_dropped", 12, 34, 56);

    // rejected load, then a tick during LOAD
    set_hr = 5'd10; set_min = 6'd60; set_sec = 6'd0;
    set_valid = 1'b1; step(); set_valid = 1'b0;
    chk("bad_load_err24", err_a, 1);
    chk("bad_load_err12", err_b, 1);
    step();
    chk("bad_load_err_off", err_a, 0);
    chk_time("bad_load_keep", 12, 34, 56);
    idle(2);
    set_hr = 5'd1; set_min = 6'd2; set_sec = 6'd3;
    set_valid = 1'b1; step();
    set_valid = 1'b0; tick = 1'b1; step();
    tick = 1'b0;
    chk_time("pend_load", 1, 2, 3);
    step();
    chk("pend_adv_sec", sec_a, 3);
    step();
    chk_time("pend_applied", 1, 2, 4);

`ifdef RTC_TIMEKEEPER_ALARM_EN
    // alarm at 00:00:05
    idle(3);
    alarm_hr = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd5; alarm_arm = 1'b1;
    load(0, 0, 4);
    idle(2);
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    chk("alarm_pre", af_a, 0);
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("alarm_time_sec", sec_a, 5);
    chk("alarm_n2", af_a, 0);
    step();
    chk("alarm_n3_24", af_a, 1);
    chk("alarm_n3_12", af_b, 1);
    idle(5);
    chk("alarm_held", af_a, 1);
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    chk("alarm_cleared", af_a, 0);
    alarm_arm = 1'b0;
`endif

    // reset in the middle of an ADVANCE
    idle(3);
    load(5, 6, 7);
    idle(2);
    tick = 1'b1; step(); tick = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk_time("rst_adv", 0, 0, 0);
    chk("rst_adv_day", day_a, 0);
    chk("rst_adv_hr12", hr_b, 0);
    chk("rst_adv_ready", rdy_a, 1);

    // randomized traffic around the carry and wrap points
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      set_valid = ($urandom_range(0, 9) == 0);
      set_sec = 6'($urandom_range(50, 61));
      set_min = 6'($urandom_range(57, 60));
      set_hr = 5'($urandom_range(9, 24));
      rst = ($urandom_range(0, 199) == 0);
`ifdef RTC_TIMEKEEPER_ALARM_EN
      alarm_sec = 6'($urandom_range(57, 59));
      alarm_min = 6'd59;
      alarm_hr = 5'($urandom_range(10, 11));
      alarm_arm = ($urandom_range(0, 4) != 0);
      alarm_clr = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    rst = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
